// File: rtl/incline_fusion.sv
// Roll-incline fusion stage: integrates the offset-compensated roll rate and
// pulls it toward the accelerometer incline. The integrator is seeded from the accelerometer at start-up.
module incline_fusion #(
  parameter logic signed [15:0] ROLL_OFF    = 16'sd80,
  parameter logic signed [15:0] AY_OFF      = 16'sd0,
  parameter int                 FUSION_STEP = 1024,
  parameter int                 SETTLE      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] AY,
  input  logic signed [15:0] AZ,
  output logic signed [12:0] incline,
  output logic               incline_vld,
  output logic               settled
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = 32;
  localparam int INT_W  = 27;
  localparam int SUM_W  = INT_W + 1;
  localparam int INC_W  = 13;
  localparam int FRAC_W = INT_W - INC_W;
  localparam logic signed [COEF_W-1:0] ACC_COEF = 16'sd327;

  typedef enum logic {SEED, RUN} state_t;

  logic signed [DATA_W-1:0] roll_comp_p1;
  logic signed [DATA_W-1:0] ay_comp_p1;
  logic                     az_pos_p1;
  logic                     vld_p1;

  logic signed [PROD_W-1:0] acc_prod;
  logic signed [INC_W-1:0]  incline_acc;
  logic signed [SUM_W-1:0]  fusion;
  logic signed [SUM_W-1:0]  sum;
  logic signed [INT_W-1:0]  roll_int;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;

  // Clamp a 28-bit sum into the 27-bit integrator range instead of wrapping.
  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1] != v[SUM_W-2])
      sat_int = v[SUM_W-1] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    else
      sat_int = v[INT_W-1:0];
  endfunction

  // Stage 1: offset compensation, captured only on valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      roll_comp_p1 <= '0;
      ay_comp_p1   <= '0;
      az_pos_p1    <= 1'b0;
    end else begin
      vld_p1 <= vld;
      if (vld) begin
        roll_comp_p1 <= roll_rt - ROLL_OFF;
        ay_comp_p1   <= AY - AY_OFF;
        az_pos_p1    <= (AZ > 16'sd0);
      end
    end
  end

  assign acc_prod    = PROD_W'(ay_comp_p1) * PROD_W'(ACC_COEF);
  assign incline_acc = INC_W'(acc_prod >>> 13);
  assign incline     = roll_int[INT_W-1:FRAC_W];

  // Correction is suppressed when gravity is not on +Z (sensor upside down or in free fall).
  always_comb begin
    fusion = '0;
    if (az_pos_p1) begin
      if (incline_acc > incline)
        fusion = SUM_W'(FUSION_STEP);
      else if (incline_acc < incline)
        fusion = SUM_W'(-FUSION_STEP);
    end
  end

  assign sum = SUM_W'(roll_int) - SUM_W'(roll_comp_p1) + fusion;

  always_comb begin
    state_nxt = state;
    if (state == SEED && vld_p1 && settle_cnt == 8'(SETTLE - 1))
      state_nxt = RUN;
  end

  // Stage 2: seed or integrate, and publish the incline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEED;
      settle_cnt  <= '0;
      settled     <= 1'b0;
      incline_vld <= 1'b0;
      roll_int    <= '0;
    end else begin
      state       <= state_nxt;
      incline_vld <= vld_p1;
      settled     <= (state_nxt == RUN);
      if (vld_p1) begin
        if (state == SEED) begin
          roll_int   <= {incline_acc, {FRAC_W{1'b0}}};
          settle_cnt <= settle_cnt + 8'd1;
        end else begin
          roll_int <= sat_int(sum);
        end
      end
    end
  end

endmodule

// File: tb/tb_incline_fusion.sv
// Scoreboard bench for incline_fusion: stimulus pushes model-predicted results,
// a negedge monitor pops and compares on every incline_vld.
module tb_incline_fusion;

  localparam logic signed [15:0] ROLL_OFF = 16'sd80;
  localparam logic signed [15:0] AY_OFF   = 16'sd0;
  localparam longint             FUSION   = 1024;
  localparam int                 SETTLE   = 4;
  localparam longint             INT_MAX  = 64'sd67108863;
  localparam longint             INT_MIN  = -64'sd67108864;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic signed [15:0] roll_rt = '0;
  logic signed [15:0] ay = '0;
  logic signed [15:0] az = '0;
  logic signed [12:0] incline;
  logic incline_vld;
  logic settled;

  incline_fusion #(
    .ROLL_OFF(ROLL_OFF), .AY_OFF(AY_OFF), .FUSION_STEP(1024), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .roll_rt(roll_rt), .AY(ay), .AZ(az),
    .incline(incline), .incline_vld(incline_vld), .settled(settled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [12:0] inc;
    logic               stl;
    int                 due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int pulses = 0;

  longint m_int;
  int     m_cnt;
  bit     m_run;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_int = 0;
    m_cnt = 0;
    m_run = 1'b0;
  endfunction

  task automatic model_step(input logic signed [15:0] r, input logic signed [15:0] a,
                            input logic signed [15:0] z,
                            output logic signed [12:0] inc, output logic stl);
    logic signed [15:0] rc, ac;
    logic signed [12:0] acc;
    longint prod, cur, fus;
    rc   = r - ROLL_OFF;
    ac   = a - AY_OFF;
    prod = longint'(ac) * 327;
    acc  = 13'(prod >>> 13);
    cur  = m_int >>> 14;
    if (!m_run) begin
      m_int = longint'(acc) * 16384;
      m_cnt++;
      if (m_cnt == SETTLE) m_run = 1'b1;
    end else begin
      fus = 0;
      if (z > 16'sd0) begin
        if (acc > cur) fus = FUSION;
        else if (acc < cur) fus = -FUSION;
      end
      m_int = m_int - longint'(rc) + fus;
      if (m_int > INT_MAX) m_int = INT_MAX;
      if (m_int < INT_MIN) m_int = INT_MIN;
    end
    inc = 13'(m_int >>> 14);
    stl = m_run;
  endtask

  // Called at posedge+1; the sample is taken on the next edge.
  task automatic send(input logic signed [15:0] r, input logic signed [15:0] a,
                      input logic signed [15:0] z);
    exp_t e;
    roll_rt = r;
    ay      = a;
    az      = z;
    vld     = 1'b1;
    model_step(r, a, z, e.inc, e.stl);
    e.due = cyc + 2;
    q.push_back(e);
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && incline_vld) begin
      pulses++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_vld: incline_vld high with no pending sample, incline=%0d", incline);
      end else begin
        e = q.pop_front();
        chk("incline", incline, e.inc);
        chk("settled", settled, e.stl);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin : stim
    int p0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_incline", incline, 0);
    chk("rst_incline_vld", incline_vld, 0);
    chk("rst_settled", settled, 0);

    // Seed from AY = 8192: 8192*327 >> 13 = 327
    repeat (3) send(16'sd80, 16'sd8192, 16'sh3000);
    idle(2);
    chk("seed3_settled", settled, 0);
    send(16'sd80, 16'sd8192, 16'sh3000);
    idle(2);
    chk("seed_incline", incline, 327);
    chk("seed_settled", settled, 1);
    idle(3);
    chk("hold_incline", incline, 327);

    // Reset while a sample is in flight
    send(16'sd80, 16'sd8192, 16'sh3000);
    rst_n = 1'b0;
    #1;
    chk("midrst_incline", incline, 0);
    chk("midrst_incline_vld", incline_vld, 0);
    chk("midrst_settled", settled, 0);
    q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    chk("midrst_no_vld", incline_vld, 0);

    // Full SETTLE count again after reset, seeding with AY = 0
    repeat (3) send(16'sd80, 16'sd0, 16'sh3000);
    idle(2);
    chk("reseed3_settled", settled, 0);
    send(16'sd80, 16'sd0, 16'sh3000);
    idle(2);
    chk("reseed4_settled", settled, 1);
    chk("reseed_incline", incline, 0);

    // Gyro integration with fusion enabled
    send(16'sd16464, 16'sd0, 16'sh3000);
    idle(2);
    chk("gyro1_incline", incline, -1);
    send(16'sd16464, 16'sd0, 16'sh3000);
    idle(2);
    chk("gyro2_incline", incline, -2);
    chk("gyro2_roll_int", dut.roll_int, -31744);

    // Same scenario with fusion gated off by AZ <= 0
    do_reset();
    repeat (4) send(16'sd80, 16'sd0, 16'sh3000);
    send(16'sd16464, 16'sd0, -16'sd4096);
    idle(2);
    chk("gate1_incline", incline, -1);
    send(16'sd16464, 16'sd0, -16'sd4096);
    idle(2);
    chk("gate2_incline", incline, -2);
    chk("gate2_roll_int", dut.roll_int, -32768);

    // Positive saturation: roll_comp = -32768 per sample
    repeat (3000) send(16'sh8050, 16'sd0, 16'sh3000);
    idle(2);
    chk("satpos_incline", incline, 4095);
    chk("satpos_roll_int", dut.roll_int, INT_MAX);
    repeat (5) send(16'sh8050, 16'sd0, 16'sh3000);
    idle(2);
    chk("satpos_hold", incline, 4095);

    // Negative saturation: 16'h8000 - 80 wraps to +32688
    repeat (4500) send(16'sh8000, 16'sd0, -16'sd4096);
    idle(2);
    chk("satneg_incline", incline, -4096);
    chk("satneg_roll_int", dut.roll_int, INT_MIN);

    // Back-to-back: 4 seeds then 8 run samples, no gaps
    do_reset();
    p0 = pulses;
    repeat (4) send(16'sd80, 16'sd8192, 16'sh3000);
    send(16'sd1000,   16'sd8192,  16'sh3000);
    send(-16'sd500,   16'sd4096,  16'sh3000);
    send(16'sd80,    -16'sd8192,  16'sh3000);
    send(16'sd20000,  16'sd0,    -16'sd4096);
    send(-16'sd20000, 16'sd1000,  16'sh3000);
    send(16'sd80,     16'sd8192,  16'sh3000);
    send(16'sd16464,  16'sd0,     16'sh3000);
    send(16'sd300,   -16'sd4096,  16'sd1);
    drain();
    idle(2);
    chk("b2b_pulses", pulses - p0, 12);
    chk("b2b_final_incline", incline, m_int >>> 14);
    chk("b2b_final_roll_int", dut.roll_int, m_int);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
